ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter_pick.sv | 29 ++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter: FSM states, port indices
// and default bus widths.
package fpg8_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two master ports and the RAM pin group seen by ram_arbiter.
interface ram_arbiter_if import fpg8_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              ram_w_en;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output ram_w_en, ram_r_en, ram_addr, ram_w_data,
    input  ram_r_data,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  ram_w_en, ram_r_en, ram_addr, ram_w_data,
    output ram_r_data,
    input  busy
  );

endinterface

// File: rtl/ram_arbiter_pick.sv
// Two-way winner selection. ARB_ROUND_ROBIN_EN selects alternating ties;
// otherwise the CPU wins every tie.
module arb_pick import fpg8_arb_pkg::*; (
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic last_gnt,
  output logic any_req,
  output logic winner
);

  logic tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_winner = other_port(last_gnt);
`else
  logic unused_last;
  assign unused_last = last_gnt;
  assign tie_winner  = PORT_CPU;
`endif

  assign any_req = cpu_req | ldr_req;

  always_comb begin
    winner = PORT_CPU;
    if (cpu_req && ldr_req) winner = tie_winner;
    else if (ldr_req)       winner = PORT_LDR;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the CPU and loader ports; tie policy
// comes from arb_pick (ARB_ROUND_ROBIN_EN).
module ram_arbiter import fpg8_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t state, state_nxt;
  logic   grant;
  logic   any_req, winner;
  acc_t   sel;

  logic              cur_port, cur_we, last_gnt;
  logic              cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
  logic              ram_w_en, ram_r_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data, cpu_rdata, ldr_rdata;

  arb_pick u_pick (
    .cpu_req  (bus.cpu_req),
    .ldr_req  (bus.ldr_req),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .winner   (winner)
  );

  always_comb begin
    sel.we    = bus.cpu_we;
    sel.addr  = bus.cpu_addr;
    sel.wdata = bus.cpu_wdata;
    if (winner == PORT_LDR) begin
      sel.we    = bus.ldr_we;
      sel.addr  = bus.ldr_addr;
      sel.wdata = bus.ldr_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = cur_we ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are single-cycle: cleared every edge unless re-asserted below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_port   <= PORT_CPU;
      cur_we     <= 1'b0;
      last_gnt   <= PORT_LDR;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      ram_w_en   <= 1'b0;
      ram_r_en   <= 1'b0;
      ram_addr   <= '0;
      ram_w_data <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      ram_w_en   <= 1'b0;
      ram_r_en   <= 1'b0;
      if (grant) begin
        cur_port   <= winner;
        cur_we     <= sel.we;
        last_gnt   <= winner;
        ram_addr   <= sel.addr;
        ram_w_data <= sel.wdata;
        ram_w_en   <= sel.we;
        ram_r_en   <= ~sel.we;
        cpu_gnt    <= (winner == PORT_CPU);
        ldr_gnt    <= (winner == PORT_LDR);
      end
      // RAM output is valid during RDWAIT; only the owning port's rdata moves.
      if (state == RDWAIT) begin
        if (cur_port == PORT_CPU) begin
          cpu_rdata  <= bus.ram_r_data;
          cpu_rvalid <= 1'b1;
        end else begin
          ldr_rdata  <= bus.ram_r_data;
          ldr_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ldr_gnt    = ldr_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.ldr_rvalid = ldr_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.ldr_rdata  = ldr_rdata;
  assign bus.ram_w_en   = ram_w_en;
  assign bus.ram_r_en   = ram_r_en;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_w_data = ram_w_data;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, reset/contention sequences and random
// traffic checked by a transaction-level monitor with a shadow memory.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus();

  ram_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM behaviour: read data appears one edge after r_en.
  logic [15:0] mem    [0:4095];
  logic [15:0] shadow [0:4095];
  always @(posedge clk) begin
    if (bus.ram_r_en) bus.ram_r_data <= mem[bus.ram_addr];
    if (bus.ram_w_en) mem[bus.ram_addr] = bus.ram_w_data;
  end

  // ---------------- reference model / monitor ----------------
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          m_last = 1;
  int          gq[$];
  bit          c_exp, l_exp;
  int          c_cyc, l_cyc;
  logic [15:0] c_dat, l_dat, last_c, last_l;

  function automatic int pick(input bit c, input bit l, input int last);
    if (c && !l) return 0;
    if (l && !c) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    return (last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic mon_sync();
    m_last = 1;
    c_exp  = 1'b0;
    l_exp  = 1'b0;
    last_c = bus.cpu_rdata;
    last_l = bus.ldr_rdata;
  endtask

  task automatic monitor_step();
    int w;
    logic we;
    logic [11:0] a;
    logic [15:0] d;
    chk("excl_en", {31'd0, bus.ram_w_en & bus.ram_r_en}, 0);
    if (bus.cpu_gnt || bus.ldr_gnt) begin
      chk("gnt_onehot", {31'd0, bus.cpu_gnt & bus.ldr_gnt}, 0);
      chk("busy_on_gnt", {31'd0, bus.busy}, 1);
      w = bus.ldr_gnt ? 1 : 0;
      chk("winner", w, pick(bus.cpu_req, bus.ldr_req, m_last));
      m_last = w;
      gq.push_back(w);
      we = w ? bus.ldr_we    : bus.cpu_we;
      a  = w ? bus.ldr_addr  : bus.cpu_addr;
      d  = w ? bus.ldr_wdata : bus.cpu_wdata;
      chk("ram_addr", {20'd0, bus.ram_addr}, {20'd0, a});
      chk("ram_w_en", {31'd0, bus.ram_w_en}, {31'd0, we});
      chk("ram_r_en", {31'd0, bus.ram_r_en}, {31'd0, ~we});
      if (we) begin
        chk("ram_w_data", {16'd0, bus.ram_w_data}, {16'd0, d});
        shadow[a] = d;
      end else if (w == 0) begin
        c_exp = 1'b1; c_cyc = cyc + 2; c_dat = shadow[a];
      end else begin
        l_exp = 1'b1; l_cyc = cyc + 2; l_dat = shadow[a];
      end
    end
    if (bus.cpu_rvalid) begin
      chk("cpu_rv_expected", {31'd0, c_exp}, 1);
      chk("cpu_rv_latency", cyc, c_cyc);
      chk("cpu_rdata", {16'd0, bus.cpu_rdata}, {16'd0, c_dat});
      chk("busy_on_rvalid", {31'd0, bus.busy}, 0);
      c_exp = 1'b0;
    end else begin
      chk("cpu_rdata_hold", {16'd0, bus.cpu_rdata}, {16'd0, last_c});
      if (c_exp && cyc > c_cyc) begin
        chk("cpu_rv_missing", 1, 0);
        c_exp = 1'b0;
      end
    end
    if (bus.ldr_rvalid) begin
      chk("ldr_rv_expected", {31'd0, l_exp}, 1);
      chk("ldr_rv_latency", cyc, l_cyc);
      chk("ldr_rdata", {16'd0, bus.ldr_rdata}, {16'd0, l_dat});
      chk("busy_on_rvalid", {31'd0, bus.busy}, 0);
      l_exp = 1'b0;
    end else begin
      chk("ldr_rdata_hold", {16'd0, bus.ldr_rdata}, {16'd0, last_l});
      if (l_exp && cyc > l_cyc) begin
        chk("ldr_rv_missing", 1, 0);
        l_exp = 1'b0;
      end
    end
    last_c = bus.cpu_rdata;
    last_l = bus.ldr_rdata;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mon_en) monitor_step();
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        cr, cw;
    logic [11:0] ca;
    logic [15:0] cd;
    logic        lr, lw;
    logic [11:0] la;
    logic [15:0] ld;
    logic [15:0] exp_c, exp_l;
  } vec_t;

  vec_t vt [10];

  task automatic run_vec(input vec_t v);
    bit c_pend, l_pend, c_rd, l_rd;
    @(posedge clk); #2;
    bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
    bus.ldr_req = v.lr; bus.ldr_we = v.lw; bus.ldr_addr = v.la; bus.ldr_wdata = v.ld;
    c_pend = v.cr; l_pend = v.lr;
    c_rd = v.cr && !v.cw; l_rd = v.lr && !v.lw;
    for (int t = 0; t < 40 && (c_pend || l_pend || c_rd || l_rd); t++) begin
      @(posedge clk); #2;
      if (c_pend && bus.cpu_gnt) begin bus.cpu_req = 1'b0; c_pend = 1'b0; end
      else if (!c_pend && c_rd && bus.cpu_rvalid) c_rd = 1'b0;
      if (l_pend && bus.ldr_gnt) begin bus.ldr_req = 1'b0; l_pend = 1'b0; end
      else if (!l_pend && l_rd && bus.ldr_rvalid) l_rd = 1'b0;
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    chk("vec_timeout", {31'd0, c_pend | l_pend | c_rd | l_rd}, 0);
  endtask

  task automatic reset_mid_write();
    bit got;
    mon_en = 1'b0;
    @(posedge clk); #2;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h555; bus.cpu_wdata = 16'h1234;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(posedge clk); #2;
      got = bus.cpu_gnt;
    end
    bus.cpu_req = 1'b0;
    chk("rst_gnt_seen", {31'd0, got}, 1);
    chk("rst_w_en_before", {31'd0, bus.ram_w_en}, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_w_en", {31'd0, bus.ram_w_en}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_busy", {31'd0, bus.busy}, 0);
    chk("post_rst_gnt", {31'd0, bus.cpu_gnt | bus.ldr_gnt}, 0);
    chk("post_rst_cpu_rdata", {16'd0, bus.cpu_rdata}, 0);
    mon_sync();
    mon_en = 1'b1;
  endtask

  initial begin
    int base;
    bit to;
    vec_t rv;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 16'(i) ^ 16'hA5A5;
      shadow[i] = 16'(i) ^ 16'hA5A5;
    end
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = 0; bus.ldr_wdata = 0;

    //            cr   cw   ca      cd        lr   lw   la      ld        exp_c     exp_l
    vt[0] = '{1'b1,1'b1,12'h123,16'hBEEF,1'b0,1'b0,12'h000,16'h0000,16'h0000,16'h0000};
    vt[1] = '{1'b1,1'b0,12'h123,16'h0000,1'b0,1'b0,12'h000,16'h0000,16'hBEEF,16'h0000};
    vt[2] = '{1'b1,1'b0,12'h001,16'h0000,1'b1,1'b0,12'h002,16'h0000,16'hA5A4,16'hA5A7};
    vt[3] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,1'b1,12'hFFF,16'h1234,16'hA5A4,16'hA5A7};
    vt[4] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,1'b1,12'h000,16'h5678,16'hA5A4,16'hA5A7};
    vt[5] = '{1'b1,1'b0,12'hFFF,16'h0000,1'b0,1'b0,12'h000,16'h0000,16'h1234,16'hA5A7};
    vt[6] = '{1'b1,1'b0,12'h000,16'h0000,1'b0,1'b0,12'h000,16'h0000,16'h5678,16'hA5A7};
    vt[7] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,1'b0,12'h123,16'h0000,16'h5678,16'hBEEF};
    vt[8] = '{1'b1,1'b1,12'h010,16'hCAFE,1'b1,1'b1,12'h011,16'hF00D,16'h5678,16'hBEEF};
    vt[9] = '{1'b1,1'b0,12'h011,16'h0000,1'b1,1'b0,12'h010,16'h0000,16'hF00D,16'hCAFE};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rv_gnt",    {30'd0, bus.cpu_gnt, bus.ldr_gnt}, 0);
    chk("rv_rvalid", {30'd0, bus.cpu_rvalid, bus.ldr_rvalid}, 0);
    chk("rv_en",     {30'd0, bus.ram_w_en, bus.ram_r_en}, 0);
    chk("rv_busy",   {31'd0, bus.busy}, 0);
    chk("rv_addr",   {20'd0, bus.ram_addr}, 0);
    chk("rv_wdata",  {16'd0, bus.ram_w_data}, 0);
    chk("rv_rdata",  {bus.cpu_rdata, bus.ldr_rdata}, 0);
    #1;
    reset = 1'b0;
    mon_sync();
    mon_en = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (i == 2) reset_mid_write();
      base = gq.size();
      run_vec(vt[i]);
      if (i == 2) chk("first_after_reset_cpu", (gq.size() > base) ? gq[base] : 9, 0);
      chk($sformatf("vec%0d_cpu_rdata", i), {16'd0, bus.cpu_rdata}, {16'd0, vt[i].exp_c});
      chk($sformatf("vec%0d_ldr_rdata", i), {16'd0, bus.ldr_rdata}, {16'd0, vt[i].exp_l});
    end

    // Continuous contention: both hold write requests for 8 grants
    @(posedge clk); #2;
    base = gq.size();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h020; bus.cpu_wdata = 16'h0C0C;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 12'h021; bus.ldr_wdata = 16'h0D0D;
    to = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #2;
      if (gq.size() >= base + 8) begin to = 1'b0; break; end
    end
    bus.cpu_req = 1'b0;
    chk("contend_timeout", {31'd0, to}, 0);
    to = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #2;
      if (gq.size() >= base + 9) begin to = 1'b0; break; end
    end
    bus.ldr_req = 1'b0;
    chk("ldr_after_release_timeout", {31'd0, to}, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("contend_gnt%0d", i), (gq.size() > base + i) ? gq[base + i] : 9, i % 2);
`else
      chk($sformatf("contend_gnt%0d", i), (gq.size() > base + i) ? gq[base + i] : 9, 0);
`endif
    end
    chk("ldr_after_release", (gq.size() > base + 8) ? gq[base + 8] : 9, 1);
    repeat (3) @(posedge clk);

    // Random traffic against the monitor's shadow memory
    for (int n = 0; n < 80; n++) begin
      rv.cr = 1'($urandom_range(0, 1));
      rv.lr = rv.cr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.cw = 1'($urandom_range(0, 1));
      rv.lw = 1'($urandom_range(0, 1));
      rv.ca = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      rv.la = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(0, 15));
      rv.cd = 16'($urandom);
      rv.ld = 16'($urandom);
      rv.exp_c = 16'h0;
      rv.exp_l = 16'h0;
      run_vec(rv);
    end

    repeat (4) @(posedge clk);
    chk("end_no_pending_read", {30'd0, c_exp, l_exp}, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
